// File: rtl/pr_freelist.sv
// ---------------------------------------------------------------------------
// pr_freelist
//   Free list of physical registers for a 2-wide rename stage. A 32-entry
//   circular FIFO holds the PR numbers that are currently free. Rename pops
//   from head, and ROB commit pushes the stale PR of each committing
//   instruction at tail. arch_head marks how far head would sit if only
//   committed allocations had happened. A flush rewinds head to it, which
//   returns every speculatively allocated PR to the list.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : synchronous active-high reset
//   alloc_req[1:0] : allocation request, bit0 = slot0, bit1 = slot1
//   alloc_rdy      : allocation is permitted this cycle (>= 2 free, no flush)
//   alloc_PR0/1    : PR granted to slot0 / slot1
//   commit_vld[1:0]: per-slot commit of an instruction with a destination
//   commit_old_PR0/1 : stale PR released by each commit slot
//   flush          : misprediction / exception recovery
//   free_cnt       : number of free PRs held, 0..32
// ---------------------------------------------------------------------------
module pr_freelist (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] alloc_req,
    output logic       alloc_rdy,
    output logic [5:0] alloc_PR0,
    output logic [5:0] alloc_PR1,
    input  logic [1:0] commit_vld,
    input  logic [5:0] commit_old_PR0,
    input  logic [5:0] commit_old_PR1,
    input  logic       flush,
    output logic [5:0] free_cnt
);

    // Pointers carry a wrap bit in bit5 so that full (32) and empty (0)
    // can be told apart while bits 4:0 index the FIFO.
    logic [5:0] fifo_q [0:31];
    logic [5:0] fifo_d [0:31];
    logic [5:0] head_q, head_d;
    logic [5:0] tail_q, tail_d;
    logic [5:0] arch_head_q, arch_head_d;

    logic [5:0] head_plus1;
    logic [5:0] tail_plus1;
    logic [5:0] alloc_cnt;
    logic [5:0] commit_cnt;
    logic       alloc_fire;

    assign head_plus1 = head_q + 6'd1;
    assign tail_plus1 = tail_q + 6'd1;
    assign alloc_cnt  = {5'd0, alloc_req[0]}  + {5'd0, alloc_req[1]};
    assign commit_cnt = {5'd0, commit_vld[0]} + {5'd0, commit_vld[1]};

    // Outputs come from registered state only, so a PR pushed by commit
    // becomes visible one cycle later.
    assign free_cnt   = tail_q - head_q;
    assign alloc_rdy  = (free_cnt >= 6'd2) && !flush;
    assign alloc_fire = alloc_rdy && (alloc_req != 2'b00);

    // Slot1 takes the entry after slot0's only when slot0 is also
    // allocating; otherwise it takes the head entry itself.
    assign alloc_PR0 = fifo_q[head_q[4:0]];
    assign alloc_PR1 = alloc_req[0] ? fifo_q[head_plus1[4:0]] : fifo_q[head_q[4:0]];

    // Commit pushes go in slot order: slot0 lands at tail, slot1 lands
    // right behind it (or at tail when slot0 is idle). Pushes happen even
    // during a flush because the committing instructions are not squashed.
    always_comb begin
        fifo_d      = fifo_q;
        tail_d      = tail_q + commit_cnt;
        arch_head_d = arch_head_q + commit_cnt;
        head_d      = head_q;

        if (commit_vld[0]) begin
            fifo_d[tail_q[4:0]] = commit_old_PR0;
        end
        if (commit_vld[1]) begin
            if (commit_vld[0]) begin
                fifo_d[tail_plus1[4:0]] = commit_old_PR1;
            end else begin
                fifo_d[tail_q[4:0]] = commit_old_PR1;
            end
        end

        // Flush rewinds to the architectural head including this cycle's
        // commits; alloc_rdy is already low, so no allocation competes.
        if (flush) begin
            head_d = arch_head_d;
        end else if (alloc_fire) begin
            head_d = head_q + alloc_cnt;
        end
    end

    // Reset loads PRs 32..63 as free, since r0..r31 own PR0..PR31.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= 6'd0;
            arch_head_q <= 6'd0;
            tail_q      <= 6'b100000;
            for (int i = 0; i < 32; i++) begin
                fifo_q[i] <= 6'(32 + i);
            end
        end else begin
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            for (int i = 0; i < 32; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pr_freelist.sv
// ---------------------------------------------------------------------------
// tb_pr_freelist
//   Directed bench for pr_freelist: a table of per-cycle vectors with
//   hand-computed expected outputs, followed by hand-written sequences for
//   wrap-around, the empty list, commit-to-alloc latency and reset/flush
//   collisions.
// ---------------------------------------------------------------------------
module tb_pr_freelist;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] alloc_req;
    logic       alloc_rdy;
    logic [5:0] alloc_PR0;
    logic [5:0] alloc_PR1;
    logic [1:0] commit_vld;
    logic [5:0] commit_old_PR0;
    logic [5:0] commit_old_PR1;
    logic       flush;
    logic [5:0] free_cnt;

    int n_total = 0;
    int n_pass  = 0;

    pr_freelist dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_rdy      (alloc_rdy),
        .alloc_PR0      (alloc_PR0),
        .alloc_PR1      (alloc_PR1),
        .commit_vld     (commit_vld),
        .commit_old_PR0 (commit_old_PR0),
        .commit_old_PR1 (commit_old_PR1),
        .flush          (flush),
        .free_cnt       (free_cnt)
    );

    always #5 clk = ~clk;

    // chk mask: bit0 alloc_rdy, bit1 free_cnt, bit2 alloc_PR0, bit3 alloc_PR1
    typedef struct {
        logic       rst;
        logic       flush;
        logic [1:0] req;
        logic [1:0] cvld;
        logic [5:0] old0;
        logic [5:0] old1;
        logic [3:0] chk;
        logic       rdy;
        logic [5:0] free;
        logic [5:0] pr0;
        logic [5:0] pr1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic f, input logic [1:0] rq,
                                input logic [1:0] cv, input logic [5:0] o0,
                                input logic [5:0] o1, input logic [3:0] ck,
                                input logic rd, input logic [5:0] fr,
                                input logic [5:0] p0, input logic [5:0] p1);
        vec_t v;
        v.rst = r;  v.flush = f; v.req = rq; v.cvld = cv;
        v.old0 = o0; v.old1 = o1; v.chk = ck;
        v.rdy = rd; v.free = fr; v.pr0 = p0; v.pr1 = p1;
        return v;
    endfunction

    task automatic check1(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; also guard that the
    // stimulus never releases PR0.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        flush          = v.flush;
        alloc_req      = v.req;
        commit_vld     = v.cvld;
        commit_old_PR0 = v.old0;
        commit_old_PR1 = v.old1;
        if (v.cvld[0]) check1("commit_slot0_pr_nonzero", int'(v.old0 != 6'd0), 1);
        if (v.cvld[1]) check1("commit_slot1_pr_nonzero", int'(v.old1 != 6'd0), 1);
        #2;
    endtask

    task automatic checkOutput(input string nm, input vec_t v);
        if (v.chk[0]) check1({nm, ".alloc_rdy"}, int'(alloc_rdy), int'(v.rdy));
        if (v.chk[1]) check1({nm, ".free_cnt"},  int'(free_cnt),  int'(v.free));
        if (v.chk[2]) check1({nm, ".alloc_PR0"}, int'(alloc_PR0), int'(v.pr0));
        if (v.chk[3]) check1({nm, ".alloc_PR1"}, int'(alloc_PR1), int'(v.pr1));
        if (!v.rst && v.chk != 4'd0) check1({nm, ".free_cnt_le_32"}, int'(free_cnt <= 6'd32), 1);
    endtask

    task automatic step(input string nm, input vec_t v);
        applyStimulus(v);
        checkOutput(nm, v);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_req = 2'b00; commit_vld = 2'b00;
        commit_old_PR0 = 6'd1; commit_old_PR1 = 6'd1;

        //          rst flush req    cvld   old0   old1   chk      rdy   free    pr0     pr1
        tbl.push_back(mk(1, 0, 2'b00, 2'b00, 6'd1,  6'd1,  4'h0, 0, 6'd0,  6'd0,  6'd0));
        tbl.push_back(mk(0, 0, 2'b11, 2'b00, 6'd1,  6'd1,  4'hF, 1, 6'd32, 6'd32, 6'd33));
        tbl.push_back(mk(0, 0, 2'b00, 2'b00, 6'd1,  6'd1,  4'h7, 1, 6'd30, 6'd34, 6'd0));
        tbl.push_back(mk(1, 0, 2'b00, 2'b00, 6'd1,  6'd1,  4'h0, 0, 6'd0,  6'd0,  6'd0));
        tbl.push_back(mk(0, 0, 2'b10, 2'b00, 6'd1,  6'd1,  4'hF, 1, 6'd32, 6'd32, 6'd32));
        tbl.push_back(mk(0, 0, 2'b00, 2'b00, 6'd1,  6'd1,  4'h7, 1, 6'd31, 6'd33, 6'd0));
        tbl.push_back(mk(1, 0, 2'b00, 2'b00, 6'd1,  6'd1,  4'h0, 0, 6'd0,  6'd0,  6'd0));
        tbl.push_back(mk(0, 0, 2'b11, 2'b00, 6'd1,  6'd1,  4'hF, 1, 6'd32, 6'd32, 6'd33));
        tbl.push_back(mk(0, 0, 2'b11, 2'b00, 6'd1,  6'd1,  4'hF, 1, 6'd30, 6'd34, 6'd35));
        tbl.push_back(mk(0, 0, 2'b00, 2'b11, 6'd5,  6'd7,  4'h7, 1, 6'd28, 6'd36, 6'd0));
        tbl.push_back(mk(0, 0, 2'b11, 2'b00, 6'd1,  6'd1,  4'hF, 1, 6'd30, 6'd36, 6'd37));
        tbl.push_back(mk(0, 1, 2'b11, 2'b01, 6'd9,  6'd1,  4'h3, 0, 6'd28, 6'd0,  6'd0));
        tbl.push_back(mk(0, 0, 2'b00, 2'b00, 6'd1,  6'd1,  4'h7, 1, 6'd32, 6'd35, 6'd0));

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end
        check1("flush.head",      int'(dut.head_q),      3);
        check1("flush.arch_head", int'(dut.arch_head_q), 3);

        // Drain the whole list from head=3: indices 3..31 hold 35..63, then
        // the wrapped indices 0..2 hold the committed PRs 5, 7, 9.
        for (int k = 0; k < 14; k++) begin
            step($sformatf("drain%0d", k),
                 mk(0, 0, 2'b11, 2'b00, 6'd1, 6'd1, 4'hF, 1,
                    6'(32 - 2*k), 6'(35 + 2*k), 6'(36 + 2*k)));
        end
        step("drain_wrap", mk(0, 0, 2'b11, 2'b00, 6'd1, 6'd1, 4'hF, 1, 6'd4, 6'd63, 6'd5));
        step("drain_last", mk(0, 0, 2'b11, 2'b00, 6'd1, 6'd1, 4'hF, 1, 6'd2, 6'd7,  6'd9));
        step("drain_empty", mk(0, 0, 2'b00, 2'b00, 6'd1, 6'd1, 4'h3, 0, 6'd0, 6'd0, 6'd0));

        // Sixteen double allocations from reset empty the list.
        step("rstB", mk(1, 0, 2'b00, 2'b00, 6'd1, 6'd1, 4'h0, 0, 6'd0, 6'd0, 6'd0));
        for (int k = 0; k < 16; k++) begin
            step($sformatf("fill%0d", k),
                 mk(0, 0, 2'b11, 2'b00, 6'd1, 6'd1, 4'hF, 1,
                    6'(32 - 2*k), 6'(32 + 2*k), 6'(33 + 2*k)));
        end
        // Empty list: request is ignored, commits refill it for next cycle.
        step("empty_commit", mk(0, 0, 2'b11, 2'b11, 6'd40, 6'd41, 4'h3, 0, 6'd0, 6'd0, 6'd0));
        check1("empty.head_wrap", int'(dut.head_q), 32);
        // Alloc 2 and commit 1 together: 2 - 2 + 1 = 1.
        step("alloc_and_commit", mk(0, 0, 2'b11, 2'b01, 6'd42, 6'd1, 4'hF, 1, 6'd2, 6'd40, 6'd41));
        step("one_left", mk(0, 0, 2'b00, 2'b01, 6'd43, 6'd1, 4'h3, 0, 6'd1, 6'd0, 6'd0));
        step("refilled", mk(0, 0, 2'b11, 2'b00, 6'd1, 6'd1, 4'hF, 1, 6'd2, 6'd42, 6'd43));

        // Reset wins over flush, alloc and commit in the same cycle.
        step("rst_flush", mk(1, 1, 2'b11, 2'b11, 6'd50, 6'd51, 4'h0, 0, 6'd0, 6'd0, 6'd0));
        step("after_rst_flush", mk(0, 0, 2'b00, 2'b00, 6'd1, 6'd1, 4'hF, 1, 6'd32, 6'd32, 6'd32));
        check1("rst_flush.head",      int'(dut.head_q),      0);
        check1("rst_flush.tail",      int'(dut.tail_q),      32);
        check1("rst_flush.arch_head", int'(dut.arch_head_q), 0);
        step("after_rst_alloc", mk(0, 0, 2'b11, 2'b00, 6'd1, 6'd1, 4'hF, 1, 6'd32, 6'd32, 6'd33));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pr_freelist.md
PR_FREELIST -- requirements
Module: pr_freelist

Interface
REQ-001 Parameters: none; 64 physical registers (PR), 32 architectural registers, 32-entry free-list FIFO; all widths fixed.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 alloc_req  in  2  rename-slot allocation request; bit0 = slot0, bit1 = slot1.
REQ-005 alloc_rdy  out  1  allocation permitted this cycle.
REQ-006 alloc_PR0, alloc_PR1  out  6 each  PR granted to slot0 / slot1.
REQ-007 commit_vld  in  2  ROB commit of an instruction with destination; per slot.
REQ-008 commit_old_PR0, commit_old_PR1  in  6 each  stale PR released by each commit slot.
REQ-009 flush  in  1  misprediction/exception recovery.
REQ-010 free_cnt  out  6  number of free PRs held, 0..32.

Function
REQ-011 State: fifo[0:31] of 6-bit PRs; head, tail, arch_head as 6-bit pointers (bit5 = wrap, bits4:0 = index).
REQ-012 free_cnt = tail - head (mod 64), registered state only, no input dependency.
REQ-013 alloc_rdy = (free_cnt >= 2) & ~flush; independent of alloc_req, no partial grant.
REQ-014 alloc_PR0 = fifo[head]; alloc_PR1 = fifo[head+1] if alloc_req[0], else fifo[head]; both combinational from storage.
REQ-015 alloc fire = alloc_rdy & (alloc_req != 0); head advances by popcount(alloc_req) at next edge.
REQ-016 No fire -> head unchanged; alloc_PR outputs are don't-care when alloc_rdy = 0.
REQ-017 Commit: each set commit_vld bit writes its old PR at tail (slot0 first, then slot1) and advances tail by popcount(commit_vld); same cycle, arch_head advances by the same count.
REQ-018 commit_old_PRx == 0 with commit_vld[x] = 1 is illegal (PR0 is hardwired zero, never allocated or freed); bench asserts it never occurs.
REQ-019 Flush: head <= arch_head next value (including same-cycle commits); tail still takes same-cycle commit pushes; no allocation in flush cycle.
REQ-020 Simultaneous alloc and commit in a non-flush cycle: both apply; free_cnt next = free_cnt - popcount(alloc_req) + popcount(commit_vld).
REQ-021 free_cnt never exceeds 32 and never underflows; bench asserts both.
REQ-022 Wrap-around: index bits wrap 31->0 and wrap bit toggles; full (32) and empty (0) are distinguished by the wrap bit.
REQ-023 Latency: a PR pushed by commit is allocatable from the next cycle; no same-cycle bypass from commit to alloc.

Reset
REQ-024 On rst: head = 0, arch_head = 0, tail = 6'b100000, fifo[i] = 32+i for i = 0..31; free_cnt = 32, alloc_rdy = 1 next cycle.
REQ-025 rst takes priority over flush, alloc and commit in the same cycle; reset mid-operation discards all speculative and committed pushes.
REQ-026 Architectural rN maps to PR N after reset (owned by rename table, not this block).

Verification
REQ-027 Reset, alloc_req = 2'b11 for one cycle -> alloc_PR0 = 32, alloc_PR1 = 33; next cycle free_cnt = 30, alloc_PR0 = 34.
REQ-028 alloc_req = 2'b10 after reset -> alloc_PR1 = 32, head +1, free_cnt = 31.
REQ-029 Allocate 2 per cycle for 15 cycles -> free_cnt = 2, alloc_rdy = 1; one more -> free_cnt = 0, alloc_rdy = 0, head wrap bit = 1.
REQ-030 After 4 allocs (PR32-35), commit_vld = 2'b11, old PRs 5 and 7 -> fifo[0] = 5, fifo[1] = 7, free_cnt = 30, arch_head = 2.
REQ-031 Then alloc 2 more (PR36, PR37), then flush with commit_vld = 2'b01, old PR 9 -> head = arch_head = 3, free_cnt = 32, next alloc_PR0 = 35.
REQ-032 flush and rst asserted together -> state equals REQ-024 values.
